// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS32 non-pipelined datapath.
// It sequences IF/ID/Exe/Mem/WB and traps on illegal opcodes or a data-memory timeout.
// Define MIPS_CTRL_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] opcode_i,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       IRWr,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       MemtoReg,
  output logic       MemRd,
  output logic       MemWr,
  output logic       RegWr,
  output logic       PCSrc,
  output logic [2:0] state_o,
  output logic       busy,
  output logic       retire,
  output logic       err
`ifdef MIPS_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
    $error("mips_multicycle_ctrl: MEM_TIMEOUT and CNT_W must be >= 1");
  end

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              op_legal;

  assign op_legal = (opcode_i == OP_R)   || (opcode_i == OP_LW)  ||
                    (opcode_i == OP_SW)  || (opcode_i == OP_BEQ) ||
                    (opcode_i == OP_ADDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode_i;
        state_d = op_legal ? S_EXEC : S_ERR;
      end
      S_EXEC: begin
        unique case (op_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          OP_BEQ:  state_d = start ? S_FETCH : S_IDLE;
          default: state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LW) state_d = S_WB;
          else               state_d = start ? S_FETCH : S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
          // This is the MEM_TIMEOUT-th cycle without mem_ready.
          if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) state_d = S_ERR;
        end
      end
      S_WB:    state_d = start ? S_FETCH : S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    MemtoReg = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    PCSrc    = 1'b0;
    retire   = 1'b0;
    state_o  = state_q;
    busy     = (state_q != S_IDLE) && (state_q != S_ERR);
    err      = (state_q == S_ERR);

    // Operation selects stay stable across EXEC, MEM and WB.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      unique case (op_q)
        OP_R: begin
          ALUSrc = 1'b0;
          ALUOp  = 2'b10;
        end
        OP_BEQ: begin
          ALUSrc = 1'b0;
          ALUOp  = 2'b01;
        end
        default: begin
          ALUSrc = 1'b1;
          ALUOp  = 2'b00;
        end
      endcase
    end

    unique case (state_q)
      S_FETCH: IRWr = 1'b1;
      S_EXEC: begin
        if (op_q == OP_BEQ) begin
          PCWr   = 1'b1;
          PCSrc  = zero;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        MemRd = (op_q == OP_LW);
        MemWr = (op_q == OP_SW);
        if (op_q == OP_SW && mem_ready) begin
          PCWr   = 1'b1;
          retire = 1'b1;
        end
      end
      S_WB: begin
        RegWr    = 1'b1;
        MemtoReg = (op_q == OP_LW);
        PCWr     = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (busy)   cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (retire) instr_cnt_q <= instr_cnt_q + 1'b1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule
